// File: rtl/accum_bcd_pkg.sv
// Shared constants and types for the accumulator BCD display.
package accum_bcd_pkg;

    // Active-low 7-segment codes, bit order gfedcba
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    typedef enum logic {IDLE, SHIFT} state_t;

    // Ceiling log2, used to size counters that must hold the value n-1
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment code; non-BCD input shows blank.
module seg7_decode
    import accum_bcd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup, codes 10..15 blank the digit
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/accum_bcd_display.sv
// Add/subtract accumulator with wrap/saturate, sticky range error, and a
// double-dabble converter feeding registered 7-segment digits.
module accum_bcd_display
    import accum_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int LZB    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  add_en,
    input  logic                  sub,
    input  logic                  sat_mode,
    input  logic [WIDTH-1:0]      operand,
    output logic [WIDTH-1:0]      sum,
    output logic                  range_err,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int CNT_W = clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    // Returns {out_of_range, new_value}; the out-of-range bit flags wrap or clamp
    function automatic logic [WIDTH:0] acc_step(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             do_sub,
                                                input logic             sat);
        logic [WIDTH:0] r;
        logic           ovf;
        if (do_sub) begin
            r   = {1'b0, a} - {1'b0, b};
            ovf = (b > a);
        end else begin
            r   = {1'b0, a} + {1'b0, b};
            ovf = r[WIDTH];
        end
        if (ovf && sat) r[WIDTH-1:0] = do_sub ? '0 : '1;
        return {ovf, r[WIDTH-1:0]};
    endfunction

    // Double-dabble correction: add 3 to every nibble that is 5 or more
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Display shown after reset: units zero, upper digits blank or zero
    function automatic logic [7*DIGITS-1:0] reset_hex();
        logic [7*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[7*i +: 7] = (LZB != 0 && i != 0) ? SEG_BLANK : SEG_0;
        end
        return r;
    endfunction

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    bin;
    logic [BCD_W-1:0]    bcd;
    logic [WIDTH:0]      acc_res;
    logic [WIDTH-1:0]    sum_next;
    logic                load;
    logic [WIDTH-1:0]    bin_next;
    logic [BCD_W-1:0]    bcd_next;
    logic [7*DIGITS-1:0] seg_all;
    logic [7*DIGITS-1:0] hex_next;

    // Next accumulator value with clr taking priority over add_en
    always_comb begin
        acc_res  = acc_step(sum, operand, sub, sat_mode);
        load     = clr | add_en;
        sum_next = sum;
        if (clr)         sum_next = '0;
        else if (add_en) sum_next = acc_res[WIDTH-1:0];
    end

    // One double-dabble step: correct nibbles, then shift the binary MSB in
    always_comb begin
        {bcd_next, bin_next} = {add3(bcd), bin} << 1;
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .bcd (bcd_next[4*g +: 4]),
            .seg (seg_all[7*g +: 7])
        );
    end

    // Leading-zero blanking scans from the top digit down; units always shown
    always_comb begin
        logic seen;
        seen     = 1'b0;
        hex_next = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd_next[4*i +: 4] != 4'd0) seen = 1'b1;
            hex_next[7*i +: 7] = (LZB != 0 && !seen && i != 0) ? SEG_BLANK
                                                                : seg_all[7*i +: 7];
        end
    end

    // Accumulator and sticky range-error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            sum       <= '0;
            range_err <= 1'b0;
        end else begin
            sum <= sum_next;
            if (clr)                          range_err <= 1'b0;
            else if (add_en && acc_res[WIDTH]) range_err <= 1'b1;
        end
    end

    // Conversion FSM; any new sum aborts an in-flight conversion and restarts
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bin       <= '0;
            bcd       <= '0;
            busy      <= 1'b0;
            bcd_valid <= 1'b1;
            hex       <= reset_hex();
        end else if (load) begin
            state     <= SHIFT;
            cnt       <= CNT_W'(WIDTH);
            bin       <= sum_next;
            bcd       <= '0;
            busy      <= 1'b1;
            bcd_valid <= 1'b0;
        end else if (state == SHIFT) begin
            bin <= bin_next;
            bcd <= bcd_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                bcd_valid <= 1'b1;
                hex       <= hex_next;
            end
        end
    end

endmodule
